// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared sizes, pixel/word types and read-tag encoding for the VGA framebuffer arbiter.
package vga_fb_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int PIX_W = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 17;
  localparam int FIFO_DEPTH = 4;
  localparam int PPW = DATA_W / PIX_W;
  localparam int IDX_W = $clog2(PPW);
  localparam int FB_WORDS_DEF = H_ACTIVE_DEF * V_ACTIVE_DEF / PPW;
  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_SCAN, TAG_CPU} tag_t;
  function automatic int fb_words(input int h, input int v);
    return h * v / PPW;
  endfunction
  function automatic pixel_t unpack(input word_t w, input logic [IDX_W-1:0] idx);
    return w[idx*PIX_W +: PIX_W];
  endfunction
endpackage

// File: rtl/vga_fb_fifo.sv
// vga_fb_fifo: show-ahead synchronous FIFO with flush; head word is visible on o_dout while non-empty.
module vga_fb_fifo
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W = DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_din,
  output logic [W-1:0]           o_dout,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_empty = r_count == '0;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_count = r_count;
  assign o_dout = r_mem[r_rp];
  assign w_pop = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_din;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port framebuffer RAM between 4bpp VGA scanout (absolute priority) and a CPU port.
// Define VGA_FB_STATS_EN to add the saturating underflow_cnt output.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        vga_xpos,
  input  logic [9:0]        vga_ypos,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output pixel_t            pix_out,
  output logic              hsync_out,
  output logic              vsync_out,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  word_t             cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output word_t             cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output word_t             mem_wdata,
  input  word_t             mem_rdata,
  output logic              underflow
`ifdef VGA_FB_STATS_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);
  localparam int N_WORDS = fb_words(H_ACTIVE, V_ACTIVE);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic w_vis, w_active, w_restart, w_scan, w_push, w_take, w_pop, w_under, w_empty, w_full;
  logic [CW-1:0] w_count;
  logic [CW:0] w_level;
  word_t w_head;
  logic r_prev_vis, r_hs, r_vs, r_underflow;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [IDX_W-1:0] r_idx;
  tag_t r_tag;
  pixel_t r_pix;
  assign w_vis = vga_ypos < 10'(V_ACTIVE);
  assign w_active = w_vis && vga_xpos < 10'(H_ACTIVE);
  assign w_restart = !w_vis && r_prev_vis;
  // A read already in flight counts as occupied so a prefetch can never overrun the FIFO.
  assign w_level = {1'b0, w_count} + (CW+1)'(r_tag == TAG_SCAN);
  assign w_scan = !rst && !w_restart && !w_full && w_level < (CW+1)'(FIFO_DEPTH)
                  && r_fetch_addr < ADDR_W'(N_WORDS);
  assign cpu_gnt = !rst && !w_scan && cpu_req;
  assign mem_addr = w_scan ? r_fetch_addr : cpu_addr;
  assign mem_we = cpu_gnt && cpu_we;
  assign mem_wdata = cpu_wdata;
  assign cpu_rvalid = r_tag == TAG_CPU;
  assign cpu_rdata = mem_rdata;
  assign w_push = r_tag == TAG_SCAN && !w_restart;
  assign w_take = w_active && r_idx == IDX_W'(PPW-1);
  assign w_pop = w_take && !w_empty;
  assign w_under = w_take && w_empty;
  assign pix_out = r_pix;
  assign hsync_out = r_hs;
  assign vsync_out = r_vs;
  assign underflow = r_underflow;
  vga_fb_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_restart),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (mem_rdata),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix <= '0;
      r_hs <= 1'b1;
      r_vs <= 1'b1;
      r_prev_vis <= 1'b0;
      r_fetch_addr <= '0;
      r_idx <= '0;
      r_tag <= TAG_NONE;
      r_underflow <= 1'b0;
    end else begin
      r_hs <= hsync_in;
      r_vs <= vsync_in;
      r_prev_vis <= w_vis;
      r_pix <= (w_active && !w_empty) ? unpack(w_head, r_idx) : '0;
      r_tag <= w_scan ? TAG_SCAN : (cpu_gnt && !cpu_we) ? TAG_CPU : TAG_NONE;
      r_fetch_addr <= w_restart ? '0 : r_fetch_addr + ADDR_W'(w_scan);
      r_idx <= w_restart ? '0 : r_idx + IDX_W'(w_active);
      r_underflow <= r_underflow | w_under;
    end
  end
`ifdef VGA_FB_STATS_EN
  logic [15:0] r_underflow_cnt;
  assign underflow_cnt = r_underflow_cnt;
  always_ff @(posedge clk)
    if (rst) r_underflow_cnt <= '0;
    else if (w_under && r_underflow_cnt != '1) r_underflow_cnt <= r_underflow_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench for vga_fb_arbiter on a reduced 16x2 frame (8 framebuffer words).
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;
  localparam int H = 16;
  localparam int V = 2;
  logic clk = 0, rst = 1;
  logic [9:0] vga_xpos = 0, vga_ypos = 0;
  logic hsync_in = 0, vsync_in = 0;
  pixel_t pix_out;
  logic hsync_out, vsync_out;
  logic cpu_req = 0, cpu_we = 0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  word_t cpu_wdata = '0;
  logic cpu_gnt, cpu_rvalid;
  word_t cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_we;
  word_t mem_wdata, mem_rdata;
  logic underflow;
`ifdef VGA_FB_STATS_EN
  logic [15:0] underflow_cnt;
`endif
  int n_cmp = 0, n_err = 0;
  int w_cyc = 0, w_gnt = 0;
  pixel_t pq[$];
  word_t rq[$];
  bit chk_pix = 0, act_d = 0, hs_d = 1, vs_d = 1, win = 0;
  word_t ram [256];

  always #5 clk = ~clk;

  vga_fb_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst(rst), .vga_xpos(vga_xpos), .vga_ypos(vga_ypos),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pix_out(pix_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .underflow(underflow)
`ifdef VGA_FB_STATS_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  always @(posedge clk) begin
    act_d <= chk_pix && !rst && vga_xpos < H && vga_ypos < V;
    hs_d <= rst | hsync_in;
    vs_d <= rst | vsync_in;
  end

  function automatic word_t word_of(input int k);
    return (k == 5) ? 16'hBEEF : 16'h3210 + 16'(k);
  endfunction

  function automatic pixel_t nib(input int k, input int i);
    word_t d;
    d = word_of(k);
    return d[i*4 +: 4];
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (act_d) begin
      if (pq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pix: got %0h with no expected pixel queued", pix_out);
      end else chk("pix", pix_out, pq.pop_front());
    end
    if (cpu_rvalid) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rdata: got %0h with no expected read queued", cpu_rdata);
      end else chk("rdata", cpu_rdata, rq.pop_front());
    end
    chk("hsync", hsync_out, hs_d);
    chk("vsync", vsync_out, vs_d);
  end

  always @(negedge clk)
    if (win && cpu_req) begin
      w_cyc <= w_cyc + 1;
      if (cpu_gnt) w_gnt <= w_gnt + 1;
    end

  task automatic drive(input int x, input int y, input pixel_t e);
    vga_xpos = 10'(x);
    vga_ypos = 10'(y);
    hsync_in = (x != H + 1);
    vsync_in = (y != V + 1);
    if (chk_pix && !rst && x < H && y < V) pq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int y, input int n, input bit zero);
    for (int x = 0; x < n; x++) drive(x, y, zero ? 4'h0 : nib(y * (H / 4) + x / 4, x % 4));
    if (n == H) for (int x = H; x < H + 4; x++) drive(x, y, 4'h0);
  endtask

  task automatic vblank(input int n);
    for (int i = 0; i < n; i++) drive(H, (i < 3) ? V + 1 : V, 4'h0);
  endtask

  task automatic cpu_op(input bit we, input int a, input word_t d, input word_t e);
    bit got;
    got = 0;
    cpu_req = 1;
    cpu_we = we;
    cpu_addr = ADDR_W'(a);
    cpu_wdata = d;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (cpu_gnt) begin
        got = 1;
        chk("mem_we_on_gnt", mem_we, we);
        chk("mem_addr_on_gnt", mem_addr, a);
        if (!we) rq.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    cpu_req = 0;
    chk("cpu_gnt_seen", got, 1);
    chk("rvalid_latency", cpu_rvalid, !we);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) ram[k] = word_of(k);
    rst = 1;
    hsync_in = 0;
    vsync_in = 0;
    vga_xpos = 10'(H);
    vga_ypos = 10'(V);
    cpu_req = 1;
    cpu_we = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix", pix_out, 0);
    chk("rst_hsync", hsync_out, 1);
    chk("rst_vsync", vsync_out, 1);
    chk("rst_gnt", cpu_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_underflow", underflow, 0);
`ifdef VGA_FB_STATS_EN
    chk("rst_ucnt", underflow_cnt, 0);
`endif
    rst = 0;
    cpu_req = 0;
    cpu_we = 0;
    vblank(10);
    chk("prefill_count", dut.u_fifo.o_count, 4);
    chk("prefill_addr", dut.r_fetch_addr, 4);
    chk_pix = 1;
    fork
      begin
        win = 1;
        line(0, H, 0);
        win = 0;
        line(1, H, 0);
      end
      begin
        for (int i = 0; i < 20; i++) cpu_op(1, 64 + i, 16'hA000 + 16'(i), 16'h0);
        cpu_op(0, 5, 16'h0, 16'hBEEF);
        cpu_op(0, 64, 16'h0, 16'hA000);
        cpu_op(0, 83, 16'h0, 16'hA013);
      end
    join
    chk("gnt_ratio", w_gnt * 4 >= w_cyc * 3, 1);
    chk("gnt_window", w_cyc >= 16, 1);
    chk("no_underflow_cpu", underflow, 0);
    vblank(10);
    line(0, H, 0);
    line(1, H, 0);
    chk("no_underflow_frame", underflow, 0);
    line(0, H, 1);
    chk("fetch_saturated", dut.r_fetch_addr, 8);
    chk("underflow_set", underflow, 1);
`ifdef VGA_FB_STATS_EN
    chk("underflow_cnt", underflow_cnt, 4);
`endif
    vblank(10);
    chk("underflow_sticky", underflow, 1);
    line(0, 5, 0);
    vga_xpos = 10'(H);
    vga_ypos = 10'(V);
    hsync_in = 1;
    vsync_in = 1;
    @(negedge clk);
    chk("inflight_at_restart", dut.r_tag == TAG_SCAN, 1);
    @(posedge clk);
    #1;
    chk("flush_count", dut.u_fifo.o_count, 0);
    chk("flush_addr", dut.r_fetch_addr, 0);
    chk("flush_idx", dut.r_idx, 0);
    chk("restart_fetch", mem_addr, 0);
    vblank(10);
    line(0, 6, 0);
    chk_pix = 0;
    rst = 1;
    vga_xpos = 10'd6;
    hsync_in = 0;
    vsync_in = 0;
    cpu_req = 1;
    cpu_we = 1;
    @(posedge clk);
    #1;
    chk("midrst_pix", pix_out, 0);
    chk("midrst_hsync", hsync_out, 1);
    chk("midrst_vsync", vsync_out, 1);
    chk("midrst_gnt", cpu_gnt, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_underflow", underflow, 0);
    chk("midrst_addr", dut.r_fetch_addr, 0);
    rst = 0;
    cpu_req = 0;
    cpu_we = 0;
    for (int x = 7; x < H + 4; x++) drive(x, 0, 4'h0);
    line(1, H, 0);
    vblank(10);
    chk_pix = 1;
    line(0, H, 0);
    line(1, H, 0);
    vblank(4);
    chk("post_rst_underflow", underflow, 0);
    chk("pix_q_drained", pq.size(), 0);
    chk("rd_q_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
